// File: rtl/lmc_microwire_rx.sv
// lmc_microwire_rx
// Receive side of the STE microwire link, modelling the LMC1992 volume/tone
// controller. Frames from the shifter's microwire master are deserialised,
// the last FRAME_BITS bits are decoded, and the resulting mixer settings are
// held for the DMA-sound/YM mixing stage.
//
// Optional feature: define LMC_RX_RAMP_EN to make master/left/right step one
// unit toward their decoded targets every RAMP_DIV clk32 cycles instead of
// jumping immediately.
//
// Parameters:
//   SYNC_STAGES  synchroniser depth on mw_clk/mw_data/mw_en (>= 2)
//   FRAME_BITS   command length; decode assumes the 11-bit LMC1992 layout
//                {addr[1:0], sel[2:0], data[5:0]}
//   RAMP_DIV     clk32 cycles per volume step (ramp build only)
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a synchronised mw_en rising edge
// SHIFT  | frame open; shift one bit per synchronised mw_clk rise
// DECODE | one cycle: validate the frame and apply or reject it

module lmc_microwire_rx #(
   parameter int SYNC_STAGES = 2,
   parameter int FRAME_BITS  = 11,
   parameter int RAMP_DIV    = 256
) (
   input  logic       clk32_i,
   input  logic       resb_i,
   input  logic       mw_clk_i,
   input  logic       mw_data_i,
   input  logic       mw_en_i,
   output logic [5:0] master_vol_o,
   output logic [4:0] left_vol_o,
   output logic [4:0] right_vol_o,
   output logic [3:0] bass_o,
   output logic [3:0] treble_o,
   output logic [1:0] mix_o,
   output logic       cmd_stb_o,
   output logic       frame_err_o
);

   if (SYNC_STAGES < 2 || FRAME_BITS < 11 || RAMP_DIV < 1) begin : g_param_check
      $error("lmc_microwire_rx: SYNC_STAGES >= 2, FRAME_BITS >= 11, RAMP_DIV >= 1 required");
   end

   localparam logic [5:0] MASTER_RST = 6'd40;
   localparam logic [4:0] SIDE_RST   = 5'd20;
   localparam logic [3:0] TONE_RST   = 4'd6;
   localparam logic [1:0] MIX_RST    = 2'd1;

   localparam logic [5:0] MASTER_MAX = 6'd40;
   localparam logic [4:0] SIDE_MAX   = 5'd20;
   localparam logic [3:0] TONE_MAX   = 4'd12;

   localparam logic [2:0] SEL_MIX    = 3'b000;
   localparam logic [2:0] SEL_BASS   = 3'b001;
   localparam logic [2:0] SEL_TREBLE = 3'b010;
   localparam logic [2:0] SEL_MASTER = 3'b011;
   localparam logic [2:0] SEL_RIGHT  = 3'b100;
   localparam logic [2:0] SEL_LEFT   = 3'b101;

   localparam logic [1:0] ADDR_LMC   = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_DECODE = 2'd2
   } state_t;

   // ------------------------------------------------------------------
   // Input synchronisers and edge detection
   // ------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] clk_sync_q;
   logic [SYNC_STAGES-1:0] data_sync_q;
   logic [SYNC_STAGES-1:0] en_sync_q;
   logic                   clk_prev_q;
   logic                   en_prev_q;

   logic clk_s;
   logic data_s;
   logic en_s;
   logic clk_rise;
   logic en_rise;
   logic en_fall;

   // Bring the asynchronous microwire pins into the clk32 domain.
   always_ff @(posedge clk32_i or negedge resb_i) begin
      if (!resb_i) begin
         clk_sync_q  <= '0;
         data_sync_q <= '0;
         en_sync_q   <= '0;
      end else begin
         clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0],  mw_clk_i};
         data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], mw_data_i};
         en_sync_q   <= {en_sync_q[SYNC_STAGES-2:0],   mw_en_i};
      end
   end

   // Previous synchronised levels for edge detection.
   always_ff @(posedge clk32_i or negedge resb_i) begin
      if (!resb_i) begin
         clk_prev_q <= 1'b0;
         en_prev_q  <= 1'b0;
      end else begin
         clk_prev_q <= clk_s;
         en_prev_q  <= en_s;
      end
   end

   assign clk_s    = clk_sync_q[SYNC_STAGES-1];
   assign data_s   = data_sync_q[SYNC_STAGES-1];
   assign en_s     = en_sync_q[SYNC_STAGES-1];
   assign clk_rise = clk_s & ~clk_prev_q;
   assign en_rise  = en_s & ~en_prev_q;
   assign en_fall  = ~en_s & en_prev_q;

   // ------------------------------------------------------------------
   // Frame FSM, shift register and decoded settings
   // ------------------------------------------------------------------
   state_t                 state_q, state_d;
   logic [FRAME_BITS-1:0]  sr_q, sr_d;
   logic [3:0]             cnt_q, cnt_d;
   logic                   cmd_stb_q, cmd_stb_d;
   logic                   frame_err_q, frame_err_d;

   logic [1:0]             mix_q, mix_d;
   logic [3:0]             bass_q, bass_d;
   logic [3:0]             treble_q, treble_d;
   logic [5:0]             master_set_q, master_set_d;
   logic [4:0]             left_set_q, left_set_d;
   logic [4:0]             right_set_q, right_set_d;

   logic [1:0]             fr_addr;
   logic [2:0]             fr_sel;
   logic [5:0]             fr_data;
   logic                   fr_long;
   logic                   fr_ok;

   assign fr_addr = sr_q[FRAME_BITS-1 -: 2];
   assign fr_sel  = sr_q[FRAME_BITS-3 -: 3];
   assign fr_data = sr_q[5:0];
   assign fr_long = (int'(cnt_q) >= FRAME_BITS);
   assign fr_ok   = fr_long && (fr_addr == ADDR_LMC);

   function automatic logic [3:0] clamp_tone(input logic [3:0] v);
      return (v > TONE_MAX) ? TONE_MAX : v;
   endfunction

   function automatic logic [5:0] clamp_master(input logic [5:0] v);
      return (v > MASTER_MAX) ? MASTER_MAX : v;
   endfunction

   function automatic logic [4:0] clamp_side(input logic [4:0] v);
      return (v > SIDE_MAX) ? SIDE_MAX : v;
   endfunction

   // State, shift register, bit counter, pulses and settings registers.
   always_ff @(posedge clk32_i or negedge resb_i) begin
      if (!resb_i) begin
         state_q      <= ST_IDLE;
         sr_q         <= '0;
         cnt_q        <= '0;
         cmd_stb_q    <= 1'b0;
         frame_err_q  <= 1'b0;
         mix_q        <= MIX_RST;
         bass_q       <= TONE_RST;
         treble_q     <= TONE_RST;
         master_set_q <= MASTER_RST;
         left_set_q   <= SIDE_RST;
         right_set_q  <= SIDE_RST;
      end else begin
         state_q      <= state_d;
         sr_q         <= sr_d;
         cnt_q        <= cnt_d;
         cmd_stb_q    <= cmd_stb_d;
         frame_err_q  <= frame_err_d;
         mix_q        <= mix_d;
         bass_q       <= bass_d;
         treble_q     <= treble_d;
         master_set_q <= master_set_d;
         left_set_q   <= left_set_d;
         right_set_q  <= right_set_d;
      end
   end

   // Next-state logic: frame capture and command decode.
   always_comb begin
      state_d      = state_q;
      sr_d         = sr_q;
      cnt_d        = cnt_q;
      cmd_stb_d    = 1'b0;
      frame_err_d  = 1'b0;
      mix_d        = mix_q;
      bass_d       = bass_q;
      treble_d     = treble_q;
      master_set_d = master_set_q;
      left_set_d   = left_set_q;
      right_set_d  = right_set_q;

      case (state_q)
         ST_IDLE: begin
            if (en_rise) begin
               state_d = ST_SHIFT;
               sr_d    = '0;
               cnt_d   = '0;
            end
         end

         ST_SHIFT: begin
            if (en_rise) begin
               // a fresh enable edge restarts the frame silently
               sr_d  = '0;
               cnt_d = '0;
            end else begin
               // en_prev_q lets a clock edge that coincides with the enable
               // fall still land its bit before decode
               if (clk_rise && en_prev_q) begin
                  sr_d = {sr_q[FRAME_BITS-2:0], data_s};
                  if (cnt_q != 4'd15) begin
                     cnt_d = cnt_q + 4'd1;
                  end
               end
               if (en_fall) begin
                  state_d = ST_DECODE;
               end
            end
         end

         ST_DECODE: begin
            state_d = ST_IDLE;
            if (en_rise) begin
               state_d = ST_SHIFT;
               sr_d    = '0;
               cnt_d   = '0;
            end
            if (fr_ok) begin
               cmd_stb_d = 1'b1;
               case (fr_sel)
                  SEL_MIX:    mix_d        = fr_data[1:0];
                  SEL_BASS:   bass_d       = clamp_tone(fr_data[3:0]);
                  SEL_TREBLE: treble_d     = clamp_tone(fr_data[3:0]);
                  SEL_MASTER: master_set_d = clamp_master(fr_data);
                  SEL_RIGHT:  right_set_d  = clamp_side(fr_data[4:0]);
                  SEL_LEFT:   left_set_d   = clamp_side(fr_data[4:0]);
                  default: begin
                     cmd_stb_d   = 1'b0;
                     frame_err_d = 1'b1;
                  end
               endcase
            end else begin
               frame_err_d = 1'b1;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   assign bass_o      = bass_q;
   assign treble_o    = treble_q;
   assign mix_o       = mix_q;
   assign cmd_stb_o   = cmd_stb_q;
   assign frame_err_o = frame_err_q;

`ifdef LMC_RX_RAMP_EN
   // ------------------------------------------------------------------
   // Volume ramp: decoded volumes are targets, outputs walk toward them
   // ------------------------------------------------------------------
   localparam int DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(RAMP_DIV - 1);

   logic [DIV_W-1:0] div_q, div_d;
   logic             ramp_tick;
   logic [5:0]       master_vol_q, master_vol_d;
   logic [4:0]       left_vol_q, left_vol_d;
   logic [4:0]       right_vol_q, right_vol_d;
   logic [5:0]       left_step;
   logic [5:0]       right_step;

   function automatic logic [5:0] step_toward(input logic [5:0] cur, input logic [5:0] tgt);
      if (cur < tgt) begin
         return cur + 6'd1;
      end else if (cur > tgt) begin
         return cur - 6'd1;
      end
      return cur;
   endfunction

   // Free-running divider and visible volume registers.
   always_ff @(posedge clk32_i or negedge resb_i) begin
      if (!resb_i) begin
         div_q        <= DIV_LOAD;
         master_vol_q <= MASTER_RST;
         left_vol_q   <= SIDE_RST;
         right_vol_q  <= SIDE_RST;
      end else begin
         div_q        <= div_d;
         master_vol_q <= master_vol_d;
         left_vol_q   <= left_vol_d;
         right_vol_q  <= right_vol_d;
      end
   end

   // Terminal count on the down-counter moves each volume one step.
   always_comb begin
      ramp_tick    = (div_q == '0);
      div_d        = ramp_tick ? DIV_LOAD : div_q - 1'b1;
      left_step    = step_toward({1'b0, left_vol_q},  {1'b0, left_set_q});
      right_step   = step_toward({1'b0, right_vol_q}, {1'b0, right_set_q});
      master_vol_d = master_vol_q;
      left_vol_d   = left_vol_q;
      right_vol_d  = right_vol_q;
      if (ramp_tick) begin
         master_vol_d = step_toward(master_vol_q, master_set_q);
         left_vol_d   = left_step[4:0];
         right_vol_d  = right_step[4:0];
      end
   end

   assign master_vol_o = master_vol_q;
   assign left_vol_o   = left_vol_q;
   assign right_vol_o  = right_vol_q;
`else
   assign master_vol_o = master_set_q;
   assign left_vol_o   = left_set_q;
   assign right_vol_o  = right_set_q;
`endif

endmodule

// File: tb/tb_lmc_microwire_rx.sv
// Bench for lmc_microwire_rx (default build): directed frames plus random
// frames, checked by a scoreboard against a frame-level model.
`timescale 1ns/1ps

module tb_lmc_microwire_rx;

   logic       clk32   = 1'b0;
   logic       resb    = 1'b0;
   logic       mw_clk  = 1'b0;
   logic       mw_data = 1'b0;
   logic       mw_en   = 1'b0;
   logic [5:0] master_vol;
   logic [4:0] left_vol;
   logic [4:0] right_vol;
   logic [3:0] bass;
   logic [3:0] treble;
   logic [1:0] mix;
   logic       cmd_stb;
   logic       frame_err;

   lmc_microwire_rx dut (
      .clk32_i      (clk32),
      .resb_i       (resb),
      .mw_clk_i     (mw_clk),
      .mw_data_i    (mw_data),
      .mw_en_i      (mw_en),
      .master_vol_o (master_vol),
      .left_vol_o   (left_vol),
      .right_vol_o  (right_vol),
      .bass_o       (bass),
      .treble_o     (treble),
      .mix_o        (mix),
      .cmd_stb_o    (cmd_stb),
      .frame_err_o  (frame_err)
   );

   always #15 clk32 = ~clk32;

   typedef struct {
      bit err;
      int master;
      int left;
      int right;
      int bass;
      int treble;
      int mix;
   } exp_t;

   exp_t exp_q[$];

   int m_master = 40;
   int m_left   = 20;
   int m_right  = 20;
   int m_bass   = 6;
   int m_treble = 6;
   int m_mix    = 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk32);
      #1;
   endtask

   function automatic int min2(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   function automatic void model_reset();
      m_master = 40; m_left = 20; m_right = 20;
      m_bass = 6; m_treble = 6; m_mix = 1;
   endfunction

   // Frame-level model: the last 11 bits form {addr, sel, data}.
   function automatic void model_frame(input logic [31:0] bits, input int n);
      exp_t e;
      int   v;
      int   sel;
      int   d;
      bit   err;
      v   = int'(bits & 32'h7FF);
      sel = (v >> 6) & 7;
      d   = v & 63;
      err = (n < 11) || ((v >> 9) != 2);
      if (!err) begin
         case (sel)
            0: m_mix    = d & 3;
            1: m_bass   = min2(d & 15, 12);
            2: m_treble = min2(d & 15, 12);
            3: m_master = min2(d, 40);
            4: m_right  = min2(d & 31, 20);
            5: m_left   = min2(d & 31, 20);
            default: err = 1'b1;
         endcase
      end
      e.err = err;
      e.master = m_master; e.left = m_left; e.right = m_right;
      e.bass = m_bass; e.treble = m_treble; e.mix = m_mix;
      exp_q.push_back(e);
   endfunction

   // Sends n bits MSB first; coincide puts the last clock rise on the enable fall.
   task automatic send_frame(input logic [31:0] bits, input int n, input bit coincide);
      model_frame(bits, n);
      mw_en = 1'b1;
      cyc(4);
      for (int i = n - 1; i >= 0; i--) begin
         mw_data = bits[i];
         cyc(3);
         if (i == 0 && coincide) begin
            mw_clk = 1'b1;
            mw_en  = 1'b0;
            cyc(3);
            mw_clk = 1'b0;
         end else begin
            mw_clk = 1'b1;
            cyc(3);
            mw_clk = 1'b0;
         end
      end
      if (!coincide) begin
         cyc(3);
         mw_en = 1'b0;
      end
      mw_data = 1'b0;
      cyc(10);
   endtask

   task automatic stray_clocks(input int n);
      for (int i = 0; i < n; i++) begin
         mw_data = 1'($urandom_range(0, 1));
         cyc(3);
         mw_clk = 1'b1;
         cyc(3);
         mw_clk = 1'b0;
      end
      cyc(4);
   endtask

   task automatic check_outputs(input string tag);
      check({tag, "_master"}, int'(master_vol), m_master);
      check({tag, "_left"},   int'(left_vol),   m_left);
      check({tag, "_right"},  int'(right_vol),  m_right);
      check({tag, "_bass"},   int'(bass),       m_bass);
      check({tag, "_treble"}, int'(treble),     m_treble);
      check({tag, "_mix"},    int'(mix),        m_mix);
   endtask

   // Monitor: every pulse must match the next scoreboard entry.
   always @(negedge clk32) begin
      exp_t e;
      if (resb && (cmd_stb || frame_err)) begin
         if (exp_q.size() == 0) begin
            check("unexpected_pulse", int'({cmd_stb, frame_err}), 0);
         end else begin
            e = exp_q.pop_front();
            check("pulse_frame_err", int'(frame_err), int'(e.err));
            check("pulse_cmd_stb",   int'(cmd_stb),   int'(!e.err));
            check("sb_master", int'(master_vol), e.master);
            check("sb_left",   int'(left_vol),   e.left);
            check("sb_right",  int'(right_vol),  e.right);
            check("sb_bass",   int'(bass),       e.bass);
            check("sb_treble", int'(treble),     e.treble);
            check("sb_mix",    int'(mix),        e.mix);
         end
      end
   end

   initial begin
      logic [31:0] b;
      int          n;
      int          waited;

      repeat (5) @(posedge clk32);
      #1 resb = 1'b1;
      cyc(4);
      check("rst_cmd_stb",   int'(cmd_stb),   0);
      check("rst_frame_err", int'(frame_err), 0);
      check_outputs("rst");

      send_frame(32'b10_011_011110, 11, 1'b0);
      send_frame(32'b111_10_101_001010, 14, 1'b0);
      send_frame(32'b10_001_001111, 11, 1'b1);
      send_frame(32'b10_011_0, 6, 1'b0);
      send_frame(32'b10_100, 5, 1'b0);
      send_frame(32'b01_011_000000, 11, 1'b0);
      send_frame(32'b10_110_000001, 11, 1'b0);
      stray_clocks(3);
      check_outputs("directed");

      b = 32'b10_100_000101;
      mw_en = 1'b1;
      cyc(4);
      for (int i = 10; i > 5; i--) begin
         mw_data = b[i];
         cyc(3);
         mw_clk = 1'b1;
         cyc(3);
         mw_clk = 1'b0;
      end
      cyc(2);
      resb   = 1'b0;
      mw_en  = 1'b0;
      mw_data = 1'b0;
      model_reset();
      cyc(3);
      resb = 1'b1;
      cyc(4);
      check_outputs("midframe_rst");
      send_frame(32'b10_000_000010, 11, 1'b0);

      for (int k = 0; k < 40; k++) begin
         if ($urandom_range(0, 4) == 0) n = $urandom_range(4, 10);
         else n = $urandom_range(11, 16);
         b = $urandom;
         if ($urandom_range(0, 3) != 0) b[10:9] = 2'b10;
         if ($urandom_range(0, 5) == 0) stray_clocks(2);
         send_frame(b, n, 1'($urandom_range(0, 1)));
      end

      waited = 0;
      while (exp_q.size() != 0 && waited < 200) begin
         cyc(1);
         waited++;
      end
      check("queue_drain", exp_q.size(), 0);
      check_outputs("final");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
